// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and sizing helpers.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // DONE is the state in which the result word is visible on the outputs.
  localparam int PUBLISH_STATE_IDX = 2;

  localparam int CNT_W = $clog2(DEFAULT_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'(PUBLISH_STATE_IDX)
  } state_t;

  // Bit-counter width for an arbitrary operand width; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/result handshake bundle for serial_subtractor.
// V exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             V;

  modport master (output start, A, B, Bin, input busy, done, Diff, Bout, V);
  modport slave  (input start, A, B, Bin, output busy, done, Diff, Bout, V);
`else
  modport master (output start, A, B, Bin, input busy, done, Diff, Bout);
  modport slave  (input start, A, B, Bin, output busy, done, Diff, Bout);
`endif

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational one-bit full subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one full-subtractor cell plus a borrow flop.
// Optional signed-overflow output V is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic              clk,
  input logic              rst,
  serial_subtractor_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             d;
  logic             bo;
`ifdef SERIAL_SUB_OVF_EN
  logic             sign_a;
  logic             sign_b;
`endif

  full_subtractor u_cell (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .bin (br),
    .d   (d),
    .bout(bo)
  );

  // The last RUN cycle's d is the result MSB, so the publish uses it directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      cnt       <= '0;
      br        <= 1'b0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.Diff  <= '0;
      bus.Bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      bus.V     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_sh     <= bus.A;
            b_sh     <= bus.B;
            br       <= bus.Bin;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
`ifdef SERIAL_SUB_OVF_EN
            sign_a   <= bus.A[WIDTH-1];
            sign_b   <= bus.B[WIDTH-1];
`endif
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= {d, res_sh[WIDTH-1:1]};
          br     <= bo;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.Diff <= {d, res_sh[WIDTH-1:1]};
            bus.Bout <= bo;
`ifdef SERIAL_SUB_OVF_EN
            bus.V    <= (sign_a ^ sign_b) & (d ^ sign_a);
`endif
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases, ignored starts, reset abort,
// random operations and an exhaustive back-to-back sweep against an arithmetic model.
module tb_serial_subtractor;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         v;
  } result_t;

  logic clk = 1'b0;
  logic rst;
  int   compareCount = 0;
  int   errCount = 0;
  int   cycle = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compareCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and two's-complement views.
  function automatic result_t refModel(input int a, input int b, input int bin);
    result_t r;
    int raw;
    int sa;
    int sb;
    int sr;
    raw    = a - b - bin;
    sa     = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
    sb     = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
    sr     = sa - sb - bin;
    r.diff = W'(raw);
    r.bout = (raw < 0);
    r.v    = (sr < -(1 << (W - 1))) || (sr > (1 << (W - 1)) - 1);
    return r;
  endfunction

  task automatic checkResult(input string tag, input result_t exp);
    checkOutput({tag, "_diff"}, 32'(bus.Diff), 32'(exp.diff));
    checkOutput({tag, "_bout"}, 32'(bus.Bout), 32'(exp.bout));
`ifdef SERIAL_SUB_OVF_EN
    checkOutput({tag, "_v"}, 32'(bus.V), 32'(exp.v));
`endif
  endtask

  // One full operation; noise pulses start with junk operands in RUN cycle 2 and in DONE.
  task automatic applyStimulus(input int a, input int b, input int bin, input bit noise);
    result_t exp;
    int      lat;
    bit      runOk;
    exp   = refModel(a, b, bin);
    runOk = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = W'(a);
    bus.B     = W'(b);
    bus.Bin   = 1'(bin);
    @(negedge clk);
    bus.start = 1'b0;
    bus.A     = W'($urandom);
    bus.B     = W'($urandom);
    bus.Bin   = 1'($urandom);
    checkOutput("busy_accept", 32'(bus.busy), 32'd1);
    lat = 0;
    while (!bus.done && lat < 3 * W) begin
      if (bus.busy !== 1'b1) runOk = 1'b0;
      bus.start = noise && (lat == 1);
      bus.A     = W'($urandom);
      bus.B     = W'($urandom);
      @(negedge clk);
      lat++;
    end
    checkOutput("busy_run", 32'(runOk), 32'd1);
    checkOutput("latency", 32'(lat + 1), 32'(W + 1));
    checkOutput("busy_in_done", 32'(bus.busy), 32'd0);
    checkResult("result", exp);
    bus.start = noise;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("done_pulse", 32'(bus.done), 32'd0);
    checkOutput("diff_hold", 32'(bus.Diff), 32'(exp.diff));
    @(negedge clk);
    checkOutput("stay_idle", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    result_t exp;
    result_t prevExp;
    bit      sawDone;
    int      n;
    int      lastRise;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Bin   = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkResult("rst", '0);
    rst = 1'b0;

    applyStimulus(7, 3, 0, 1'b0);
    applyStimulus(3, 7, 0, 1'b0);
    applyStimulus(0, 0, 1, 1'b0);
    applyStimulus(8, 1, 0, 1'b0);
    applyStimulus(7, 15, 0, 1'b0);
    applyStimulus(5, 2, 1, 1'b1);

    // Reset in RUN cycle 2 aborts the operation.
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = W'(6);
    bus.B     = W'(3);
    bus.Bin   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_done", 32'(bus.done), 32'd0);
    checkResult("abort", '0);
    sawDone = 1'b0;
    repeat (W + 3) begin
      @(negedge clk);
      if (bus.done) sawDone = 1'b1;
    end
    checkOutput("abort_no_done", 32'(sawDone), 32'd0);
    applyStimulus(9, 4, 0, 1'b0);

    // Reset and start on the same edge: start is dropped.
    @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    checkOutput("rst_start_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    checkOutput("rst_start_idle", 32'(bus.busy), 32'd0);

    repeat (20) applyStimulus($urandom_range(0, 15), $urandom_range(0, 15),
                              $urandom_range(0, 1), 1'($urandom));

    // Back-to-back exhaustive sweep with start held high.
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = '0;
    bus.B     = '0;
    bus.Bin   = 1'b0;
    lastRise  = 0;
    prevExp   = '0;
    for (int i = 0; i < (1 << (2 * W + 1)); i++) begin
      exp = refModel(i % 16, (i / 16) % 16, i / 256);
      n = 0;
      while (!bus.busy && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) checkOutput("b2b_accept_timeout", 32'd0, 32'd1);
      if (i > 0) begin
        checkOutput("b2b_interval", 32'(cycle - lastRise), 32'(W + 2));
        checkOutput("b2b_hold", 32'(bus.Diff), 32'(prevExp.diff));
      end
      lastRise = cycle;
      bus.A    = W'((i + 1) % 16);
      bus.B    = W'(((i + 1) / 16) % 16);
      bus.Bin  = 1'(((i + 1) / 256) % 2);
      n = 0;
      while (!bus.done && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) checkOutput("b2b_done_timeout", 32'd0, 32'd1);
      checkResult("b2b", exp);
      prevExp = exp;
      @(negedge clk);
    end
    bus.start = 1'b0;
    repeat (W + 3) @(negedge clk);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errCount);
    $finish;
  end

endmodule
